mash_mod: RTL and testbench
===========================

Name: mash_mod

Overview:
- Parametrised MASH 1-1-…-1 sigma-delta modulator, runtime-selectable order 1..4; generalisation of the fixed 4-stage chained-difference modulator.
- Each enabled step: a fractional target word is noise-shaped into a small signed integer sequence, added to an integer base word, saturated, and presented as the output code for the PWM/DAC back end.
- Adds over the previous generation: clock-enable stepping, synchronous clear, runtime order, saturation and valid flags.

Parameters:
ACC_W, 32, fractional accumulator width (target width); legal 8..32
OUT_W, 16, output code width (base and value width); legal 4..24
MAX_ORDER, 4, number of stages instantiated; legal 1..4

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
en  in  1  step strobe; one modulator step per cycle with en=1
clr  in  1  synchronous clear; relatches order
order  in  2  requested order minus 1 (0→1st … 3→4th), clamped to MAX_ORDER
target  in  ACC_W  unsigned fraction, value target/2^ACC_W
base  in  OUT_W  unsigned integer part
value  out  OUT_W  modulated output code
valid  out  1  value holds a computed sample
sat  out  1  value was clamped on this sample
carries  out  MAX_ORDER  stage carries c1..cK of newest step (debug)

Behaviour:
- Interface fixed: single clock clk; reset rst_n asynchronous, active-low.
- Reset (rst_n=0): all accumulators, pipeline registers, value, valid, sat, carries = 0; active order latched from order input on rst_n deassertion edge.
- Step model (n = count of en cycles since reset/clear), K = active order:
  - acc1[n] = (acc1[n-1] + target[n]) mod 2^ACC_W, c1[n] = carry out.
  - acck[n] = (acck[n-1] + acc(k-1)[n]) mod 2^ACC_W, ck[n] = carry out, k=2..K (same-step chaining in model).
  - y[n] = c1[n] + (1-z^-1)c2 + (1-z^-1)^2 c3 + (1-z^-1)^3 c4, stages above K contribute 0.
  - y range: K=1 0..1, K=2 -1..2, K=3 -3..4, K=4 -7..8; internal sum 5-bit signed.
- Pipeline: implementation pipelined along en only; fixed latency D=4 steps independent of K.
  - At en step m≥4 (counting from 0), value ← clamp(base[m-4] + y[m-4], 0, 2^OUT_W-1), base sampled with target.
  - sat=1 on that update iff clamping occurred, else 0.
  - valid rises on first such update and stays high until reset/clr.
- en=0: all state, value, valid, sat, carries frozen; no implicit step.
- clr=1: next edge zeroes accumulators, delay lines, pipeline, value, sat, carries; valid=0; latches order. clr overrides simultaneous en (no step taken).
- order changes without clr/reset are ignored.
- Async reset mid-run: immediate zeroing regardless of en/clr.
- carries updated on every en step (newest step, not delayed); bits above K are 0.

Optional Feature:
- Macro DITHER_EN.
- Defined: 23-bit Fibonacci LFSR (x^23+x^18+1, seed 1 at reset/clr), advanced each en step; its LSB added to stage-1 input LSB to break limit cycles.
- Undefined: no LFSR, stage-1 input equals target exactly; all Test Plan values below assume undefined.

Test Plan:
- order=3 (K=4), base=100, target=0, 20 en cycles → value=100 from step 4 on, valid=1, sat=0, carries=0.
- order=0 (K=1), base=100, target=2^(ACC_W-2), en every cycle → after valid, value repeats 100,100,100,101 with period 4.
- K=4, base=1000, target=2^(ACC_W-1), 1024 en steps after valid → every value in 993..1008; sum within 1024·1000+512 ±8.
- K=4, base=0, target=1 → some steps clamp to 0 with sat=1; base=2^OUT_W-1, target=2^ACC_W-1 → clamps to max with sat=1.
- Mid-run en held low 10 cycles → value, valid, carries unchanged; resumes exact step sequence afterwards.
- clr with en=1 and order changed 3→1 → next cycle valid=0, value=0; subsequent output matches K=2 model from step 0; rst_n pulse mid-run zeroes outputs asynchronously.

Source files
------------

// File: rtl/mash_mod.sv
// mash_mod: runtime-selectable MASH 1-1-..-1 sigma-delta modulator (order 1..MAX_ORDER).
// A fractional target is noise-shaped into a small signed integer sequence y, added to an
// integer base, saturated to [0, 2^OUT_W-1] and presented as an output code. Stepping is
// gated by en; the output trails the modulator core by a fixed 4-step delay line.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   en       step strobe, one modulator step per cycle with en=1
//   clr      synchronous clear (wins over en); relatches order
//   order    requested order minus 1, clamped to MAX_ORDER
//   target   unsigned fraction target/2^ACC_W
//   base     unsigned integer part
//   value    modulated output code
//   valid    value holds a computed sample
//   sat      value was clamped on the latest update
//   carries  stage carries c1..cK of the newest step
//
// Optional build macro: DITHER_EN adds a 23-bit LFSR (x^23+x^18+1) whose LSB is added
// into the stage-1 input LSB each step.
module mash_mod #(
  parameter int unsigned ACC_W     = 32,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned MAX_ORDER = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 clr,
  input  logic [1:0]           order,
  input  logic [ACC_W-1:0]     target,
  input  logic [OUT_W-1:0]     base,
  output logic [OUT_W-1:0]     value,
  output logic                 valid,
  output logic                 sat,
  output logic [MAX_ORDER-1:0] carries
);

  localparam logic [2:0] MaxK = 3'(MAX_ORDER);

  logic [2:0]       k_q;
  logic             pend_q;     // order not yet latched since reset release
  logic [2:0]       k_req;
  logic [2:0]       k_lim;
  logic [2:0]       k_eff;

  logic [ACC_W-1:0] acc_q [4];
  logic [ACC_W-1:0] acc_d [4];
  logic [ACC_W-1:0] stage_in;
  logic [ACC_W:0]   sum;
  logic [3:0]       c_new;
  logic [3:0]       carry_q;    // carries of the newest step, i.e. c_k[n-1] while stepping n
  logic [3:2]       p2_q;       // c3[n-2], c4[n-2]
  logic             p3_q;       // c4[n-3]
  logic [4:0]       y_new;
  logic             dith;

  logic [4:0]       dly_y_q [4];
  logic [OUT_W-1:0] dly_b_q [4];
  logic [3:0]       dly_v_q;

  logic [OUT_W+1:0] ext_y;
  logic [OUT_W+1:0] raw;
  logic [OUT_W-1:0] clamped;
  logic             clip;

  logic [OUT_W-1:0] value_q;
  logic             valid_q;
  logic             sat_q;

  assign k_req = {1'b0, order} + 3'd1;
  assign k_lim = (k_req > MaxK) ? MaxK : k_req;
  // On the first edge after reset release the order input is used directly.
  assign k_eff = pend_q ? k_lim : k_q;

`ifdef DITHER_EN
  logic [22:0] lfsr_q;
  assign dith = lfsr_q[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= 23'd1;
    end else if (clr) begin
      lfsr_q <= 23'd1;
    end else if (en) begin
      lfsr_q <= {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
    end
  end
`else
  assign dith = 1'b0;
`endif

  // Same-step chained accumulators; stages at or above K hold zero.
  always_comb begin
    stage_in = target;
    sum      = '0;
    c_new    = '0;
    for (int k = 0; k < 4; k++) begin
      acc_d[k] = '0;
      if (k < int'(k_eff)) begin
        sum = {1'b0, acc_q[k]} + {1'b0, stage_in}
            + {{ACC_W{1'b0}}, ((k == 0) ? dith : 1'b0)};
        acc_d[k] = sum[ACC_W-1:0];
        c_new[k] = sum[ACC_W];
        stage_in = sum[ACC_W-1:0];
      end
    end
  end

  // y = c1 + (1-z^-1)c2 + (1-z^-1)^2 c3 + (1-z^-1)^3 c4, 5-bit two's complement wrap.
  always_comb begin
    y_new = {4'b0, c_new[0]}
          + {4'b0, c_new[1]} - {4'b0, carry_q[1]}
          + {4'b0, c_new[2]} - {3'b0, carry_q[2], 1'b0} + {4'b0, p2_q[2]}
          + {4'b0, c_new[3]} - {3'b0, carry_q[3], carry_q[3]}
          + {3'b0, p2_q[3], p2_q[3]} - {4'b0, p3_q};
  end

  // Saturating add of the oldest delayed sample.
  always_comb begin
    ext_y   = {{(OUT_W - 3){dly_y_q[3][4]}}, dly_y_q[3]};
    raw     = {2'b00, dly_b_q[3]} + ext_y;
    clamped = raw[OUT_W-1:0];
    clip    = 1'b0;
    if (raw[OUT_W+1]) begin
      clamped = '0;
      clip    = 1'b1;
    end else if (raw[OUT_W]) begin
      clamped = '1;
      clip    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q     <= 3'd0;
      pend_q  <= 1'b1;
      carry_q <= '0;
      p2_q    <= '0;
      p3_q    <= 1'b0;
      dly_v_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]   <= '0;
        dly_y_q[i] <= '0;
        dly_b_q[i] <= '0;
      end
    end else if (clr) begin
      k_q     <= k_lim;
      pend_q  <= 1'b0;
      carry_q <= '0;
      p2_q    <= '0;
      p3_q    <= 1'b0;
      dly_v_q <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i]   <= '0;
        dly_y_q[i] <= '0;
        dly_b_q[i] <= '0;
      end
    end else begin
      if (pend_q) begin
        k_q    <= k_lim;
        pend_q <= 1'b0;
      end
      if (en) begin
        for (int i = 0; i < 4; i++) begin
          acc_q[i] <= acc_d[i];
        end
        carry_q <= c_new;
        p2_q    <= carry_q[3:2];
        p3_q    <= p2_q[3];
        dly_y_q[0] <= y_new;
        dly_b_q[0] <= base;
        dly_v_q    <= {dly_v_q[2:0], 1'b1};
        for (int i = 1; i < 4; i++) begin
          dly_y_q[i] <= dly_y_q[i-1];
          dly_b_q[i] <= dly_b_q[i-1];
        end
        if (dly_v_q[3]) begin
          value_q <= clamped;
          sat_q   <= clip;
          valid_q <= 1'b1;
        end
      end
    end
  end

  assign value   = value_q;
  assign valid   = valid_q;
  assign sat     = sat_q;
  assign carries = carry_q[MAX_ORDER-1:0];

endmodule

// File: tb/tb_mash_mod.sv
// tb_mash_mod: self-checking bench for mash_mod (default parameters, DITHER_EN undefined).
// Directed vectors from a table, hand-written corner sequences, and randomized stimulus,
// all compared every cycle against a behavioural MASH model held in the bench.
module tb_mash_mod;

  localparam int unsigned ACC_W     = 32;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned MAX_ORDER = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic                 clr;
  logic [1:0]           order;
  logic [ACC_W-1:0]     target;
  logic [OUT_W-1:0]     base;
  logic [OUT_W-1:0]     value;
  logic                 valid;
  logic                 sat;
  logic [MAX_ORDER-1:0] carries;

  mash_mod #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .MAX_ORDER(MAX_ORDER)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .clr    (clr),
    .order  (order),
    .target (target),
    .base   (base),
    .value  (value),
    .valid  (valid),
    .sat    (sat),
    .carries(carries)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- behavioural model ----------------
  longint m_acc [4];
  int     m_hist [4][4];   // m_hist[k][j] = carry of stage k+1, j steps ago
  int     m_pend_q [$];    // base + y awaiting the 4-step latency
  int     m_k;
  bit     m_pend;
  int     m_value;
  int     m_valid;
  int     m_sat;
  int     m_car;

  function automatic int binom(input int n, input int r);
    int b = 1;
    for (int i = 0; i < r; i++) b = b * (n - i) / (i + 1);
    return b;
  endfunction

  function automatic int clamp_k(input logic [1:0] o);
    int k = int'(o) + 1;
    return (k > int'(MAX_ORDER)) ? int'(MAX_ORDER) : k;
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0;
      for (int j = 0; j < 4; j++) m_hist[k][j] = 0;
    end
    m_pend_q.delete();
    m_value = 0; m_valid = 0; m_sat = 0; m_car = 0;
  endtask

  task automatic model_reset();
    model_zero();
    m_pend = 1'b1;
    m_k    = 1;
  endtask

  task automatic model_edge(input logic e, input logic c, input logic [1:0] o,
                            input logic [ACC_W-1:0] t, input logic [OUT_W-1:0] b);
    longint mod = longint'(1) << ACC_W;
    longint in_v;
    longint s;
    int     y;
    int     v;
    if (m_pend) begin
      m_k = clamp_k(o);
      m_pend = 1'b0;
    end
    if (c) begin
      model_zero();
      m_k = clamp_k(o);
    end else if (e) begin
      in_v  = longint'(t);
      m_car = 0;
      for (int k = 3; k >= 0; k--)
        for (int j = 3; j > 0; j--) m_hist[k][j] = m_hist[k][j-1];
      for (int k = 0; k < 4; k++) begin
        m_hist[k][0] = 0;
        if (k < m_k) begin
          s = m_acc[k] + in_v;
          m_hist[k][0] = (s >= mod) ? 1 : 0;
          m_acc[k] = s % mod;
          in_v = m_acc[k];
          m_car = m_car | (m_hist[k][0] << k);
        end
      end
      // Stage k+1 sees the k-th backward difference of its carry stream.
      y = 0;
      for (int k = 0; k < m_k; k++)
        for (int j = 0; j <= k; j++)
          y += (((j % 2) == 1) ? -1 : 1) * binom(k, j) * m_hist[k][j];
      m_pend_q.push_back(int'(b) + y);
      if (m_pend_q.size() > 4) begin
        v = m_pend_q.pop_front();
        m_valid = 1;
        if (v < 0) begin
          m_value = 0; m_sat = 1;
        end else if (v > (1 << OUT_W) - 1) begin
          m_value = (1 << OUT_W) - 1; m_sat = 1;
        end else begin
          m_value = v; m_sat = 0;
        end
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model.value",   32'(value),   32'(m_value));
    chk("model.valid",   32'(valid),   32'(m_valid));
    chk("model.sat",     32'(sat),     32'(m_sat));
    chk("model.carries", 32'(carries), 32'(m_car));
  endtask

  task automatic cyc(input logic e, input logic c, input logic [1:0] o,
                     input logic [ACC_W-1:0] t, input logic [OUT_W-1:0] b);
    en = e; clr = c; order = o; target = t; base = b;
    @(posedge clk);
    model_edge(e, c, o, t, b);
    #1;
    check_model();
  endtask

  task automatic do_reset(input logic [1:0] o);
    rst_n = 1'b0;
    en = 1'b0; clr = 1'b0; order = o; target = '0; base = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]       order;
    logic [ACC_W-1:0] target;
    logic [OUT_W-1:0] base;
    int               nsteps;
    logic [OUT_W-1:0] exp_value;
    logic             exp_valid;
    logic             exp_sat;
    logic             chk_car;
    logic [3:0]       exp_car;
  } vec_t;

  vec_t vecs [10];

  logic [OUT_W-1:0] snap_value;
  logic             snap_valid;
  logic [3:0]       snap_car;
  longint           acc_sum;
  int               vmin;
  int               vmax;

  initial begin
    vecs[0] = '{2'd3, 32'h0000_0000, 16'd100,   20, 16'd100,   1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[1] = '{2'd0, 32'h4000_0000, 16'd100,    4, 16'd0,     1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[2] = '{2'd0, 32'h4000_0000, 16'd100,    5, 16'd100,   1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[3] = '{2'd0, 32'h4000_0000, 16'd100,    8, 16'd101,   1'b1, 1'b0, 1'b1, 4'b0001};
    vecs[4] = '{2'd3, 32'h8000_0000, 16'd0,      6, 16'd2,     1'b1, 1'b0, 1'b1, 4'b0101};
    vecs[5] = '{2'd3, 32'h8000_0000, 16'd0,      7, 16'd0,     1'b1, 1'b1, 1'b1, 4'b0010};
    vecs[6] = '{2'd3, 32'h8000_0000, 16'd1000,   7, 16'd999,   1'b1, 1'b0, 1'b1, 4'b0010};
    vecs[7] = '{2'd3, 32'hFFFF_FFFF, 16'hFFFF,   5, 16'hFFFF,  1'b1, 1'b0, 1'b0, 4'b0000};
    vecs[8] = '{2'd3, 32'hFFFF_FFFF, 16'hFFFF,   6, 16'hFFFF,  1'b1, 1'b1, 1'b0, 4'b0000};
    vecs[9] = '{2'd1, 32'h8000_0000, 16'd50,     7, 16'd51,    1'b1, 1'b0, 1'b1, 4'b0010};

    do_reset(2'd3);
    chk("reset.value",   32'(value),   32'd0);
    chk("reset.valid",   32'(valid),   32'd0);
    chk("reset.sat",     32'(sat),     32'd0);
    chk("reset.carries", 32'(carries), 32'd0);

    // Each vector: clr with en=1 latches order, then steps with a different (ignored) order.
    foreach (vecs[i]) begin
      cyc(1'b1, 1'b1, vecs[i].order, vecs[i].target, vecs[i].base);
      for (int s = 0; s < vecs[i].nsteps; s++)
        cyc(1'b1, 1'b0, ~vecs[i].order, vecs[i].target, vecs[i].base);
      chk($sformatf("vec%0d.value", i), 32'(value), 32'(vecs[i].exp_value));
      chk($sformatf("vec%0d.valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d.sat", i),   32'(sat),   32'(vecs[i].exp_sat));
      if (vecs[i].chk_car)
        chk($sformatf("vec%0d.carries", i), 32'(carries), 32'(vecs[i].exp_car));
    end

    // Long K=4 run at target 1/2: bounded output swing, mean tracks base + 1/2.
    cyc(1'b1, 1'b1, 2'd3, 32'h8000_0000, 16'd1000);
    repeat (4) cyc(1'b1, 1'b0, 2'd3, 32'h8000_0000, 16'd1000);
    acc_sum = 0; vmin = 1 << 30; vmax = -1;
    for (int s = 0; s < 1024; s++) begin
      cyc(1'b1, 1'b0, 2'd3, 32'h8000_0000, 16'd1000);
      acc_sum += longint'(value);
      if (int'(value) < vmin) vmin = int'(value);
      if (int'(value) > vmax) vmax = int'(value);
    end
    chk("long.min_ge_993", 32'(vmin >= 993), 32'd1);
    chk("long.max_le_1008", 32'(vmax <= 1008), 32'd1);
    chk("long.sum_window",
        32'((acc_sum >= 1024512 - 8) && (acc_sum <= 1024512 + 8)), 32'd1);

    // en held low: everything frozen, then the step sequence resumes (model tracks it).
    snap_value = value; snap_valid = valid; snap_car = carries;
    for (int s = 0; s < 10; s++) begin
      cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom(), 16'($urandom()));
      chk("hold.value",   32'(value),   32'(snap_value));
      chk("hold.valid",   32'(valid),   32'(snap_valid));
      chk("hold.carries", 32'(carries), 32'(snap_car));
    end
    repeat (12) cyc(1'b1, 1'b0, 2'd3, 32'h8000_0000, 16'd1000);

    // clr with en=1 and order changed to 1 (K=2), then random K=2 traffic.
    cyc(1'b1, 1'b1, 2'd1, 32'h1234_5678, 16'd500);
    chk("clr.valid", 32'(valid), 32'd0);
    chk("clr.value", 32'(value), 32'd0);
    for (int s = 0; s < 30; s++) cyc(1'b1, 1'b0, 2'd3, $urandom(), 16'($urandom_range(0, 4)));

    // Asynchronous reset mid-cycle.
    repeat (6) cyc(1'b1, 1'b0, 2'd2, $urandom(), 16'd300);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.value",   32'(value),   32'd0);
    chk("arst.valid",   32'(valid),   32'd0);
    chk("arst.carries", 32'(carries), 32'd0);
    en = 1'b1; clr = 1'b0; order = 2'd2;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int s = 0; s < 20; s++) cyc(1'b1, 1'b0, 2'd0, $urandom(), 16'd300);

    // Randomized traffic with occasional clr and order changes, extremes weighted.
    for (int s = 0; s < 3000; s++) begin
      logic [ACC_W-1:0] t;
      logic [OUT_W-1:0] b;
      case ($urandom_range(0, 5))
        0: t = '0;
        1: t = '1;
        2: t = 32'h8000_0000;
        default: t = $urandom();
      endcase
      case ($urandom_range(0, 4))
        0: b = 16'($urandom_range(0, 8));
        1: b = 16'hFFFF - 16'($urandom_range(0, 8));
        default: b = 16'($urandom());
      endcase
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
          2'($urandom_range(0, 3)), t, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
